// File: rtl/cmp_seq_unit.sv
// Multi-word relational compare, most-significant word first, with a single
// registered result stage and valid/ready on both sides.
module cmp_seq_unit #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_signed,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_res,
   output logic             out_lt,
   output logic             out_eq,
   output logic             out_gt,
   output logic             out_err
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   localparam logic [2:0] OP_EQ = 3'd0;
   localparam logic [2:0] OP_NE = 3'd1;
   localparam logic [2:0] OP_GT = 3'd2;
   localparam logic [2:0] OP_GE = 3'd3;
   localparam logic [2:0] OP_LT = 3'd4;
   localparam logic [2:0] OP_LE = 3'd5;

   typedef enum logic {FIRST, REST} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            dlt_q, dlt_d, dgt_q, dgt_d;
   logic            valid_q, res_q, lt_q, eq_q, gt_q, err_q;

   logic            accept, word_signed, w_lt, w_gt;
   logic            overrun, finish, eq_d, res_d, reserved_d;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Only the most-significant word carries the sign, so signedness is
   // taken straight from the first beat and never needs storing.
   assign word_signed = (state_q == FIRST) && in_signed;
   assign w_lt = word_signed ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
   assign w_gt = word_signed ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      dlt_d = dlt_q;
      dgt_d = dgt_q;
      cnt_d = cnt_q;
      op_d  = op_q;
      if (state_q == FIRST) begin
         dlt_d = w_lt;
         dgt_d = w_gt;
         cnt_d = CW'(1);
         op_d  = in_op;
      end else begin
         if (!(dlt_q || dgt_q)) begin
            dlt_d = w_lt;
            dgt_d = w_gt;
         end
         cnt_d = cnt_q + 1'b1;
      end
      overrun    = !in_last && (cnt_d == CW'(MAX_BEATS));
      finish     = in_last || overrun;
      eq_d       = !(dlt_d || dgt_d);
      reserved_d = 1'b0;
      case (op_d)
         OP_EQ:   res_d = eq_d;
         OP_NE:   res_d = !eq_d;
         OP_GT:   res_d = dgt_d;
         OP_GE:   res_d = dgt_d || eq_d;
         OP_LT:   res_d = dlt_d;
         OP_LE:   res_d = dlt_d || eq_d;
         default: begin
            res_d      = 1'b0;
            reserved_d = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FIRST;
         cnt_q   <= '0;
         op_q    <= '0;
         dlt_q   <= 1'b0;
         dgt_q   <= 1'b0;
         valid_q <= 1'b0;
         res_q   <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            dlt_q   <= dlt_d;
            dgt_q   <= dgt_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            state_q <= finish ? FIRST : REST;
         end
         // A finishing beat can only be accepted when the old result is gone
         // or leaving this cycle, so loading here never drops a result.
         if (accept && finish) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
            lt_q    <= dlt_d;
            gt_q    <= dgt_d;
            eq_q    <= eq_d;
            err_q   <= reserved_d || overrun;
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_res   = res_q;
   assign out_lt    = lt_q;
   assign out_eq    = eq_q;
   assign out_gt    = gt_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Directed bench for cmp_seq_unit with hand-computed expected results.
module tb_cmp_seq_unit;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, in_signed, in_last;
   logic [7:0] in_a, in_b;
   logic [2:0] in_op;
   logic       out_valid, out_ready, out_res, out_lt, out_eq, out_gt, out_err;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] EQ = 3'd0, GT = 3'd2, LT = 3'd4, LE = 3'd5;

   always #5 clk = ~clk;

   cmp_seq_unit #(.WIDTH(8), .MAX_BEATS(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_lt(out_lt), .out_eq(out_eq), .out_gt(out_gt), .out_err(out_err)
   );

   // Packed view of outputs: {valid, res, lt, eq, gt, err}
   wire [5:0] outs = {out_valid, out_res, out_lt, out_eq, out_gt, out_err};

   // Drive one beat at the falling edge, wait (bounded) for in_ready, return #1 after accept.
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic sgn, input logic last, input logic rdy);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_signed = sgn; in_last = last;
      out_ready = rdy;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
      in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (outs !== 6'b000000) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 000000", outs);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single_beat();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pre_result_valid: got %b required 0", out_valid);
      end
      beat(8'h80, 8'h7F, GT, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b110010) begin
         errors++;
         $display("FAIL unsigned_gt: got %b required 110010", outs);
      end
      beat(8'h80, 8'h7F, GT, 1'b1, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b101000) begin
         errors++;
         $display("FAIL signed_gt: got %b required 101000", outs);
      end
      beat(8'h55, 8'h55, LE, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b110100) begin
         errors++;
         $display("FAIL le_equal: got %b required 110100", outs);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop: got %b required 0", out_valid);
      end
   endtask

   task automatic test_multi_beat();
      beat(8'h00, 8'h00, LT, 1'b1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mb_mid_valid: got %b required 0", out_valid);
      end
      beat(8'h12, 8'h13, GT, 1'b0, 1'b0, 1'b1);
      beat(8'hFF, 8'h00, GT, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b111000) begin
         errors++;
         $display("FAIL mb_signed_lt: got %b required 111000", outs);
      end
      // Negative top word decides signed compare; same words unsigned give GT.
      beat(8'hFF, 8'h00, GT, 1'b1, 1'b0, 1'b1);
      beat(8'h00, 8'hFF, GT, 1'b1, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b101000) begin
         errors++;
         $display("FAIL mb_signed_msw: got %b required 101000", outs);
      end
      beat(8'hFF, 8'h00, GT, 1'b0, 1'b0, 1'b1);
      beat(8'h00, 8'hFF, GT, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b110010) begin
         errors++;
         $display("FAIL mb_unsigned_msw: got %b required 110010", outs);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      beat(8'h80, 8'h7F, GT, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== 6'b110010 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: got outs=%b in_ready=%b required 110010 0", i, outs, in_ready);
         end
         @(posedge clk);
         #1;
      end
      beat(8'h01, 8'h02, LT, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b111000) begin
         errors++;
         $display("FAIL back_to_back: got %b required 111000", outs);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drop: got %b required 0", out_valid);
      end
   endtask

   task automatic test_errors();
      beat(8'h03, 8'h03, 3'd6, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b100101) begin
         errors++;
         $display("FAIL reserved_op: got %b required 100101", outs);
      end
      beat(8'h01, 8'h02, LT, 1'b0, 1'b0, 1'b1);
      beat(8'h05, 8'h05, LT, 1'b0, 1'b0, 1'b1);
      beat(8'h07, 8'h07, LT, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_early: got %b required 0", out_valid);
      end
      beat(8'h00, 8'h09, LT, 1'b0, 1'b0, 1'b1);
      checks++;
      if (outs !== 6'b111001) begin
         errors++;
         $display("FAIL overrun_result: got %b required 111001", outs);
      end
      // Fifth beat opens a new GT transaction; the EQ code on its last beat is ignored.
      beat(8'h09, 8'h03, GT, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_new_txn: got %b required 0", out_valid);
      end
      beat(8'h04, 8'h04, EQ, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b110010) begin
         errors++;
         $display("FAIL after_overrun: got %b required 110010", outs);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      beat(8'h80, 8'h7F, GT, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (outs !== 6'b000000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_pending: got outs=%b in_ready=%b required 000000 1", outs, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      beat(8'h05, 8'h01, GT, 1'b0, 1'b0, 1'b1);
      beat(8'h05, 8'h01, GT, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_valid: got %b required 0", out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      beat(8'h0A, 8'h0A, EQ, 1'b0, 1'b1, 1'b1);
      checks++;
      if (outs !== 6'b110100) begin
         errors++;
         $display("FAIL eq_after_reset: got %b required 110100", outs);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
